// File: rtl/codificador_hamming_tx.sv
// rtl/codificador_hamming_tx.sv - SECDED (8,4) Hamming encoder with serial LSB-first transmitter.
// Optional macro INYECCION_ERROR_EN adds err_en/err_pos to invert one codeword bit at acceptance.
module codificador_hamming_tx #(
   parameter int CICLOS_POR_BIT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] dato_in,
`ifdef INYECCION_ERROR_EN
   input  logic       err_en,
   input  logic [2:0] err_pos,
`endif
   input  logic       dato_valid,
   output logic       dato_ready,
   output logic [7:0] palabra_cod,
   output logic       cod_valid,
   output logic       tx_bit,
   output logic       tx_activo,
   output logic       tx_fin
);

   if (CICLOS_POR_BIT < 1) begin : g_param_invalido
      $error("codificador_hamming_tx: CICLOS_POR_BIT must be >= 1");
   end

   localparam int CW = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS_POR_BIT - 1);

   typedef enum logic [1:0] {REPOSO, TRANSMITE, FIN} estado_t;

   estado_t          estado_q, estado_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       palabra_q, palabra_d;
   logic             cod_valid_q, cod_valid_d;

   logic             aceptar;
   logic             fin_bit;
   logic             ultimo_bit;
   logic [7:0]       cod_nuevo;

   assign aceptar    = dato_valid && (estado_q == REPOSO);
   assign fin_bit    = (cnt_q == CNT_MAX);
   assign ultimo_bit = fin_bit && (idx_q == 3'd7);

   always_comb begin
      logic p1, p2, p4, p0;
      p1 = dato_in[0] ^ dato_in[1] ^ dato_in[3];
      p2 = dato_in[0] ^ dato_in[2] ^ dato_in[3];
      p4 = dato_in[1] ^ dato_in[2] ^ dato_in[3];
      p0 = p1 ^ p2 ^ dato_in[0] ^ p4 ^ dato_in[1] ^ dato_in[2] ^ dato_in[3];
      cod_nuevo = {dato_in[3], dato_in[2], dato_in[1], p4, dato_in[0], p2, p1, p0};
`ifdef INYECCION_ERROR_EN
      if (err_en) begin
         cod_nuevo = cod_nuevo ^ (8'b1 << err_pos);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= REPOSO;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         palabra_q   <= '0;
         cod_valid_q <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         palabra_q   <= palabra_d;
         cod_valid_q <= cod_valid_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         REPOSO:    if (aceptar) estado_d = TRANSMITE;
         TRANSMITE: if (ultimo_bit) estado_d = FIN;
         FIN:       estado_d = REPOSO;
         default:   estado_d = REPOSO;
      endcase
   end

   // Shift register is loaded once at acceptance, so dato_in changes cannot reach the stream.
   always_comb begin
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      palabra_d   = palabra_q;
      cod_valid_d = aceptar;
      if (aceptar) begin
         palabra_d = cod_nuevo;
         shift_d   = cod_nuevo;
         cnt_d     = '0;
         idx_d     = '0;
      end else if (estado_q == TRANSMITE) begin
         if (fin_bit) begin
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_comb begin
      dato_ready  = (estado_q == REPOSO);
      tx_activo   = (estado_q == TRANSMITE);
      tx_fin      = (estado_q == FIN);
      tx_bit      = (estado_q == TRANSMITE) && shift_q[0];
      palabra_cod = palabra_q;
      cod_valid   = cod_valid_q;
   end

endmodule

// File: tb/tb_codificador_hamming_tx.sv
// tb/tb_codificador_hamming_tx.sv - self-checking bench for codificador_hamming_tx.
// Main instance uses 3 cycles per bit; a second instance checks the 1-cycle-per-bit build.
module tb_codificador_hamming_tx;

   localparam int CPB = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] dato_in;
   logic       dato_valid;
   logic       dato_ready;
   logic [7:0] palabra_cod;
   logic       cod_valid, tx_bit, tx_activo, tx_fin;

   logic [3:0] d1_in;
   logic       d1_valid, d1_ready, d1_cval, d1_tx, d1_act, d1_fin;
   logic [7:0] d1_pal;

`ifdef INYECCION_ERROR_EN
   logic       err_en;
   logic [2:0] err_pos;
`endif

   int total = 0;
   int bad   = 0;
   int ciclo = 0;

   always #5 clk = ~clk;
   always @(posedge clk) ciclo++;

   codificador_hamming_tx #(.CICLOS_POR_BIT(CPB)) u_dut (
      .clk(clk), .rst_n(rst_n), .dato_in(dato_in),
`ifdef INYECCION_ERROR_EN
      .err_en(err_en), .err_pos(err_pos),
`endif
      .dato_valid(dato_valid), .dato_ready(dato_ready), .palabra_cod(palabra_cod),
      .cod_valid(cod_valid), .tx_bit(tx_bit), .tx_activo(tx_activo), .tx_fin(tx_fin)
   );

   codificador_hamming_tx #(.CICLOS_POR_BIT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .dato_in(d1_in),
`ifdef INYECCION_ERROR_EN
      .err_en(1'b0), .err_pos(3'd0),
`endif
      .dato_valid(d1_valid), .dato_ready(d1_ready), .palabra_cod(d1_pal),
      .cod_valid(d1_cval), .tx_bit(d1_tx), .tx_activo(d1_act), .tx_fin(d1_fin)
   );

   // Generic Hamming rule: parity k covers every data position whose index has bit k set.
   function automatic logic [7:0] modelo(input logic [3:0] w);
      logic [7:0] c;
      int datos [4];
      datos = '{3, 5, 6, 7};
      c = '0;
      for (int j = 0; j < 4; j++) c[datos[j]] = w[j];
      for (int k = 1; k <= 4; k = k * 2)
         for (int j = 0; j < 4; j++)
            if ((datos[j] & k) != 0) c[k] = c[k] ^ c[datos[j]];
      c[0] = ^c[7:1];
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      total++;
      assert (obs === esp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, esp);
      end
   endtask

   task automatic paso();
      @(posedge clk);
      #1;
   endtask

   task automatic esperar_listo();
      int n = 0;
      while (dato_ready !== 1'b1 && n < 200) begin
         paso();
         n++;
      end
      chk("ready_timeout", dato_ready, 1);
   endtask

   task automatic enviar(input logic [3:0] w, input logic [7:0] esp, input bit agitar);
      esperar_listo();
      dato_in    = w;
      dato_valid = 1'b1;
      paso();
      dato_valid = 1'b0;
      chk("cod_valid", cod_valid, 1);
      chk("palabra", palabra_cod, esp);
      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < CPB; c++) begin
            chk("tx_bit", tx_bit, esp[i]);
            chk("tx_activo", tx_activo, 1);
            if (i != 0 || c != 0) chk("cod_valid_low", cod_valid, 0);
            if (agitar) begin
               dato_in    = 4'($urandom);
               dato_valid = 1'($urandom);
            end
            paso();
         end
      end
      dato_valid = 1'b0;
      chk("fin_tx_fin", tx_fin, 1);
      chk("fin_activo", tx_activo, 0);
      chk("fin_ready", dato_ready, 0);
      chk("fin_tx_bit", tx_bit, 0);
      paso();
      chk("idle_tx_fin", tx_fin, 0);
      chk("idle_ready", dato_ready, 1);
      chk("idle_palabra", palabra_cod, esp);
      chk("idle_tx_bit", tx_bit, 0);
   endtask

   initial begin
      logic [3:0] w, wb;
      logic [7:0] e;
      int n, t0, t1;

      rst_n = 1'b0; dato_in = '0; dato_valid = 1'b0; d1_in = '0; d1_valid = 1'b0;
`ifdef INYECCION_ERROR_EN
      err_en = 1'b0; err_pos = '0;
`endif
      #2;
      chk("rst_palabra", palabra_cod, 8'h00);
      chk("rst_cod_valid", cod_valid, 0);
      chk("rst_tx_bit", tx_bit, 0);
      chk("rst_activo", tx_activo, 0);
      chk("rst_fin", tx_fin, 0);
      chk("rst_ready", dato_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      paso();

      enviar(4'b1011, 8'hAA, 1'b0);
      enviar(4'b0000, 8'h00, 1'b0);
      enviar(4'b0001, 8'h0F, 1'b0);
      enviar(4'b1111, 8'hFF, 1'b0);
      for (int r = 0; r < 8; r++) begin
         w = 4'($urandom);
         enviar(w, modelo(w), 1'b1);
      end

      // Back-to-back acceptances with dato_valid held high.
      esperar_listo();
      w  = 4'($urandom);
      wb = ~w;
      dato_in = w;
      dato_valid = 1'b1;
      n = 0;
      while (cod_valid !== 1'b1 && n < 200) begin paso(); n++; end
      chk("esp_first", cod_valid, 1);
      t0 = ciclo;
      chk("esp_pal_a", palabra_cod, modelo(w));
      dato_in = wb;
      paso();
      n = 0;
      while (cod_valid !== 1'b1 && n < 200) begin paso(); n++; end
      chk("esp_second", cod_valid, 1);
      t1 = ciclo;
      chk("espaciado", t1 - t0, 8 * CPB + 2);
      chk("esp_pal_b", palabra_cod, modelo(wb));
      dato_valid = 1'b0;

      // One bit per cycle on the CICLOS_POR_BIT=1 instance.
      e = 8'hAA;
      d1_in = 4'b1011;
      d1_valid = 1'b1;
      chk("d1_ready", d1_ready, 1);
      paso();
      d1_valid = 1'b0;
      chk("d1_cval", d1_cval, 1);
      chk("d1_pal", d1_pal, e);
      for (int i = 0; i < 8; i++) begin
         chk("d1_tx_bit", d1_tx, e[i]);
         chk("d1_activo", d1_act, 1);
         paso();
      end
      chk("d1_fin", d1_fin, 1);
      chk("d1_fin_activo", d1_act, 0);

`ifdef INYECCION_ERROR_EN
      err_en = 1'b1;
      err_pos = 3'd3;
      enviar(4'b1011, modelo(4'b1011) ^ 8'h08, 1'b0);
      chk("inj_directo", palabra_cod, 8'hA2);
      err_en = 1'b0;
      enviar(4'b1011, 8'hAA, 1'b0);
`endif

      // Reset in the middle of bit 4.
      esperar_listo();
      w = 4'($urandom);
      dato_in = w;
      dato_valid = 1'b1;
      paso();
      dato_valid = 1'b0;
      for (int i = 0; i < 4 * CPB + 1; i++) paso();
      chk("pre_rst_activo", tx_activo, 1);
      chk("pre_rst_bit", tx_bit, modelo(w)[4]);
      rst_n = 1'b0;
      #1;
      chk("arst_palabra", palabra_cod, 8'h00);
      chk("arst_cod_valid", cod_valid, 0);
      chk("arst_tx_bit", tx_bit, 0);
      chk("arst_activo", tx_activo, 0);
      chk("arst_fin", tx_fin, 0);
      chk("arst_ready", dato_ready, 1);
      paso();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         paso();
         chk("post_rst_activo", tx_activo, 0);
         chk("post_rst_ready", dato_ready, 1);
         chk("post_rst_fin", tx_fin, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/codificador_hamming_tx.md
CODIFICADOR_HAMMING_TX -- requirements
Module: codificador_hamming_tx

Interface
REQ-001 Parameter: CICLOS_POR_BIT, default 1, clock cycles each serial bit is held on tx_bit.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port dato_in  input  4  data word {w3,w2,w1,w0}.
REQ-006 Port dato_valid  input  1  dato_in valid.
REQ-007 Port dato_ready  output  1  block can accept a word.
REQ-008 Port palabra_cod  output  8  SECDED codeword, bit i = Hamming position i, bit 0 = overall parity.
REQ-009 Port cod_valid  output  1  one-cycle pulse: palabra_cod updated.
REQ-010 Port tx_bit  output  1  serial codeword bit.
REQ-011 Port tx_activo  output  1  high while tx_bit carries a codeword bit.
REQ-012 Port tx_fin  output  1  one-cycle end-of-word pulse.

Function
REQ-013 Encoding SHALL be: p1=w0^w1^w3, p2=w0^w2^w3, p4=w1^w2^w3, p0=XOR of positions 1..7.
REQ-014 Codeword layout SHALL be palabra_cod = {w3,w2,w1,p4,w0,p2,p1,p0}.
REQ-015 FSM SHALL have three states: REPOSO, TRANSMITE, FIN.
REQ-016 dato_ready SHALL be 1 only in REPOSO. A word is accepted on a rising edge with dato_valid && dato_ready.
REQ-017 On acceptance: codeword computed from dato_in at that edge and registered into palabra_cod and the shift register; state goes to TRANSMITE.
REQ-018 cod_valid SHALL pulse for exactly the first cycle after acceptance (latency 1).
REQ-019 In TRANSMITE: tx_activo=1; bits sent LSB first (palabra_cod[0] through [7]); each bit held CICLOS_POR_BIT cycles. A cycle counter runs 0..CICLOS_POR_BIT-1 and a bit index runs 0..7.
REQ-020 After the last cycle of bit 7, state SHALL go to FIN. FIN lasts one cycle with tx_fin=1, tx_activo=0, dato_ready=0. State then returns to REPOSO.
REQ-021 Accepted-word spacing SHALL be exactly 8*CICLOS_POR_BIT+2 cycles when dato_valid is held high.
REQ-022 tx_bit SHALL be 0 outside TRANSMITE.
REQ-023 palabra_cod SHALL hold its value until the next acceptance.
REQ-024 dato_in and dato_valid SHALL be ignored outside REPOSO; a changing dato_in SHALL NOT corrupt a transmission in progress.
REQ-025 CICLOS_POR_BIT<1 SHALL cause an elaboration error. CICLOS_POR_BIT=1 SHALL yield one bit per cycle.

Reset
REQ-026 rst_n low SHALL immediately force state REPOSO and clear all counters and the shift register, including mid-transmission.
REQ-027 Reset values SHALL be: palabra_cod=8'h00, cod_valid=0, tx_bit=0, tx_activo=0, tx_fin=0, dato_ready=1.
REQ-028 An aborted word SHALL NOT resume after reset release.

Configuration
REQ-029 Macro INYECCION_ERROR_EN defined: the block SHALL add input err_en (1) and input err_pos (3), sampled only at acceptance. When err_en=1, bit err_pos of the codeword SHALL be inverted in both palabra_cod and the serial stream.
REQ-030 Macro undefined: err_en and err_pos SHALL be absent and the codeword SHALL always be error-free.

Verification
REQ-031 dato_in=4'b1011 accepted -> palabra_cod=8'hAA with cod_valid pulse next cycle; tx_bit sequence 0,1,0,1,0,1,0,1; then tx_fin pulse.
REQ-032 dato_in=4'b0000 -> 8'h00; 4'b0001 -> 8'h0F; 4'b1111 -> 8'hFF.
REQ-033 CICLOS_POR_BIT=3, dato_valid held high, two words -> each bit held 3 cycles; second acceptance exactly 26 cycles after the first.
REQ-034 CICLOS_POR_BIT=2, rst_n pulsed low during bit 4 -> outputs at reset values immediately; dato_ready=1 after release; no residual tx_activo.
REQ-035 INYECCION_ERROR_EN defined, dato_in=4'b1011, err_en=1, err_pos=3 -> palabra_cod=8'hA2 (position 3, w0, inverted).
REQ-036 dato_in toggled every cycle during TRANSMITE -> serial stream equals the codeword captured at acceptance.
